mem_access_ctrl: RTL and testbench

Load/store controller sitting directly upstream of the data memory (MD) in the datapath. Accepts one byte-addressed load or store per request from the execute stage and translates it into word-indexed MD accesses, with a read-modify-write sequence for byte and halfword stores. Loads are sign- or zero-extended, and misaligned or out-of-range requests are rejected. Results return over a valid/ready response handshake, so the pipeline can stall on memory.

---
 rtl/mem_access_ctrl.sv | 174 +++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: byte-addressed load/store front end for a word-indexed
// data memory. Byte and halfword stores are done as read-modify-write. Loads
// are extracted from the addressed lanes and sign- or zero-extended.
// Responses use a valid/ready handshake, so the pipeline can stall on memory.
module mem_access_ctrl #(
  parameter int ADDR_BITS = 7
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_store,
  input  logic [1:0]  i_req_size,
  input  logic        i_req_signed,
  input  logic [31:0] i_req_addr,
  input  logic [31:0] i_req_wdata,
  output logic        o_rsp_valid,
  input  logic        i_rsp_ready,
  output logic [31:0] o_rsp_rdata,
  output logic        o_rsp_err,
  output logic [31:0] o_md_adr,
  output logic [31:0] o_md_din,
  output logic        o_md_w,
  output logic        o_md_r,
  input  logic [31:0] i_md_dout
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  state_t      r_state;
  state_t      w_nxt;

  // request fields latched at accept
  logic        r_store;
  logic [1:0]  r_size;
  logic        r_signed;
  logic [1:0]  r_off;
  logic [31:0] r_wdata;

  // output flops
  logic [31:0] r_md_adr;
  logic [31:0] r_md_din;
  logic        r_md_w;
  logic        r_md_r;
  logic        r_rsp_valid;
  logic        r_rsp_err;
  logic [31:0] r_rsp_rdata;

  logic        w_accept;
  logic        w_err;
  logic [4:0]  w_sh;
  logic [31:0] w_shifted;
  logic [31:0] w_load;
  logic [31:0] w_mask;
  logic [31:0] w_merged;

  assign w_accept = i_req_valid && (r_state == IDLE);

  // Reject illegal size, misaligned half/word, or address beyond MD depth.
  always_comb begin
    w_err = 1'b0;
    if (i_req_size == SZ_ILL)                                w_err = 1'b1;
    if (i_req_size == SZ_HALF && i_req_addr[0])             w_err = 1'b1;
    if (i_req_size == SZ_WORD && (i_req_addr[1:0] != 2'b0)) w_err = 1'b1;
    if (|i_req_addr[31:ADDR_BITS+2])                         w_err = 1'b1;
  end

  // Lane alignment: extract for loads, merge for partial stores.
  always_comb begin
    w_sh      = {r_off, 3'b000};
    w_shifted = i_md_dout >> w_sh;
    w_load    = i_md_dout;
    w_mask    = 32'h0000_00FF << w_sh;
    case (r_size)
      SZ_BYTE: w_load = {{24{r_signed & w_shifted[7]}},  w_shifted[7:0]};
      SZ_HALF: w_load = {{16{r_signed & w_shifted[15]}}, w_shifted[15:0]};
      default: w_load = i_md_dout;
    endcase
    if (r_size == SZ_HALF) w_mask = 32'h0000_FFFF << w_sh;
    w_merged = (i_md_dout & ~w_mask) | ((r_wdata << w_sh) & w_mask);
  end

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= IDLE;
    else          r_state <= w_nxt;
  end

  // Next-state logic.
  always_comb begin
    w_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (w_err)                    w_nxt = RESP;
          else if (!i_req_store)        w_nxt = READ;
          else if (i_req_size == SZ_WORD) w_nxt = WRITE;
          else                          w_nxt = READ;
        end
      end
      READ:    w_nxt = r_store ? WRITE : RESP;
      WRITE:   w_nxt = RESP;
      RESP:    if (i_rsp_ready) w_nxt = IDLE;
      default: w_nxt = IDLE;
    endcase
  end

  // Strobes and response-valid are registered from the next state so every
  // MD/RSP output comes straight from a flop.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_md_r      <= 1'b0;
      r_md_w      <= 1'b0;
      r_rsp_valid <= 1'b0;
    end else begin
      r_md_r      <= (w_nxt == READ);
      r_md_w      <= (w_nxt == WRITE);
      r_rsp_valid <= (w_nxt == RESP);
    end
  end

  // Request latch, address, write data and response data.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_store     <= 1'b0;
      r_size      <= SZ_BYTE;
      r_signed    <= 1'b0;
      r_off       <= 2'b0;
      r_wdata     <= 32'h0;
      r_md_adr    <= 32'h0;
      r_md_din    <= 32'h0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= 32'h0;
    end else if (w_accept) begin
      r_store     <= i_req_store;
      r_size      <= i_req_size;
      r_signed    <= i_req_signed;
      r_off       <= i_req_addr[1:0];
      r_wdata     <= i_req_wdata;
      r_md_adr    <= {{(32-ADDR_BITS){1'b0}}, i_req_addr[ADDR_BITS+1:2]};
      r_rsp_err   <= w_err;
      r_rsp_rdata <= 32'h0;
      // word stores skip READ, so the write word is ready at accept
      if (i_req_store && i_req_size == SZ_WORD && !w_err)
        r_md_din  <= i_req_wdata;
    end else if (r_state == READ) begin
      if (r_store) r_md_din    <= w_merged;
      else         r_rsp_rdata <= w_load;
    end
  end

  assign o_req_ready = (r_state == IDLE);
  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_rdata = r_rsp_rdata;
  assign o_rsp_err   = r_rsp_err;
  assign o_md_adr    = r_md_adr;
  assign o_md_din    = r_md_din;
  assign o_md_w      = r_md_w;
  assign o_md_r      = r_md_r;

  a_strobe_excl: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    !(r_md_r && r_md_w));

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: MD model, table of directed vectors, stall and
// reset sequences, then random traffic against a byte-level reference model.
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_store = 1'b0;
  logic [1:0]  req_size = 2'b0;
  logic        req_signed = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] md_adr;
  logic [31:0] md_din;
  logic        md_w;
  logic        md_r;
  logic [31:0] md_dout;

  int n_chk = 0;
  int n_fail = 0;

  logic [31:0] mem     [128] = '{default: 32'h0};
  logic [31:0] ref_mem [128] = '{default: 32'h0};

  mem_access_ctrl #(.ADDR_BITS(7)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req_valid(req_valid), .o_req_ready(req_ready),
    .i_req_store(req_store), .i_req_size(req_size), .i_req_signed(req_signed),
    .i_req_addr(req_addr), .i_req_wdata(req_wdata),
    .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready),
    .o_rsp_rdata(rsp_rdata), .o_rsp_err(rsp_err),
    .o_md_adr(md_adr), .o_md_din(md_din), .o_md_w(md_w), .o_md_r(md_r),
    .i_md_dout(md_dout)
  );

  always #5 clk = ~clk;

  // data memory: combinational read while strobed, write on clock edge
  assign md_dout = md_r ? mem[md_adr[6:0]] : 32'h0;
  always @(posedge clk) if (md_w) mem[md_adr[6:0]] <= md_din;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference: byte-level semantics computed with plain arithmetic.
  task automatic ref_access(input logic st, input logic [1:0] sz, input logic sg,
                            input logic [31:0] a, input logic [31:0] wd,
                            output logic [31:0] rd, output logic er,
                            output int lat, output int nr, output int nw);
    int nb, sh;
    logic [63:0] mask, val;
    logic [31:0] w;
    er = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0)
         || (a[31:9] != 23'd0);
    rd = 32'h0; lat = 1; nr = 0; nw = 0;
    if (er) return;
    nb   = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    sh   = int'(a[1:0]) * 8;
    w    = ref_mem[a[8:2]];
    mask = ((64'd1 << (8 * nb)) - 64'd1) << sh;
    if (!st) begin
      val = (64'(w) & mask) >> sh;
      if (sg && nb < 4 && val[8*nb-1]) val = val - (64'd1 << (8 * nb));
      rd = val[31:0]; lat = 2; nr = 1;
    end else begin
      val = (64'(w) & ~mask) | ((64'(wd) << sh) & mask);
      ref_mem[a[8:2]] = val[31:0];
      lat = (nb == 4) ? 2 : 3; nr = (nb == 4) ? 0 : 1; nw = 1;
    end
  endtask

  // One complete transaction; optional table expectations on top of the model.
  task automatic do_req(input string nm, input logic st, input logic [1:0] sz,
                        input logic sg, input logic [31:0] a, input logic [31:0] wd,
                        input int stall, input logic has_exp,
                        input logic [31:0] e_rd, input logic e_err, input int e_lat);
    logic [31:0] m_rd, h_rd;
    logic m_err, h_err;
    int m_lat, m_nr, m_nw, n, nr, nw;
    ref_access(st, sz, sg, a, wd, m_rd, m_err, m_lat, m_nr, m_nw);
    req_store = st; req_size = sz; req_signed = sg; req_addr = a; req_wdata = wd;
    req_valid = 1'b1;
    rsp_ready = (stall == 0);
    chk({nm, " req_ready"}, 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    n = 1; nr = 0; nw = 0;
    while (!rsp_valid && n < 8) begin
      if (md_r) nr++;
      if (md_w) nw++;
      if (md_r && md_w) chk({nm, " strobe overlap"}, 32'd1, 32'd0);
      @(posedge clk); #1;
      n++;
    end
    if (!rsp_valid) begin
      chk({nm, " rsp timeout"}, 32'd0, 32'd1);
    end else begin
      chk({nm, " latency"}, 32'(n), 32'(m_lat));
      chk({nm, " rdata"}, rsp_rdata, m_rd);
      chk({nm, " err"}, 32'(rsp_err), 32'(m_err));
      chk({nm, " md_r cycles"}, 32'(nr), 32'(m_nr));
      chk({nm, " md_w cycles"}, 32'(nw), 32'(m_nw));
      if (has_exp) begin
        chk({nm, " tbl latency"}, 32'(n), 32'(e_lat));
        chk({nm, " tbl rdata"}, rsp_rdata, e_rd);
        chk({nm, " tbl err"}, 32'(rsp_err), 32'(e_err));
      end
    end
    h_rd = rsp_rdata; h_err = rsp_err;
    for (int k = 0; k < stall; k++) begin
      @(posedge clk); #1;
      chk({nm, " stall valid"}, 32'(rsp_valid), 32'd1);
      chk({nm, " stall rdata"}, rsp_rdata, h_rd);
      chk({nm, " stall err"}, 32'(rsp_err), 32'(h_err));
      chk({nm, " stall req_ready"}, 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk({nm, " rsp drop"}, 32'(rsp_valid), 32'd0);
    if (st && !m_err) chk({nm, " mem word"}, mem[a[8:2]], ref_mem[a[8:2]]);
  endtask

  typedef struct {
    logic        st;
    logic [1:0]  sz;
    logic        sg;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] erd;
    logic        eerr;
    int          elat;
  } vec_t;

  vec_t tbl[21];

  initial begin
    logic [31:0] a, wd;
    logic [1:0] sz;
    int stall;

    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a, wd;
    logic [1:0] sz;
    logic [31:0] d_rd;
    logic d_err;
    int d_lat, d_nr, d_nw, n;

    //           st    sz    sg    addr          wdata         exp rdata     err   lat
    tbl[0]  = '{1'b1, 2'd2, 1'b0, 32'h010, 32'hDEADBEEF, 32'h0,        1'b0, 2};
    tbl[1]  = '{1'b0, 2'd2, 1'b0, 32'h010, 32'h0,        32'hDEADBEEF, 1'b0, 2};
    tbl[2]  = '{1'b1, 2'd2, 1'b0, 32'h040, 32'h11223344, 32'h0,        1'b0, 2};
    tbl[3]  = '{1'b1, 2'd0, 1'b0, 32'h043, 32'h000000A5, 32'h0,        1'b0, 3};
    tbl[4]  = '{1'b0, 2'd2, 1'b0, 32'h040, 32'h0,        32'hA5223344, 1'b0, 2};
    tbl[5]  = '{1'b1, 2'd2, 1'b0, 32'h080, 32'h8000FF80, 32'h0,        1'b0, 2};
    tbl[6]  = '{1'b0, 2'd0, 1'b1, 32'h080, 32'h0,        32'hFFFFFF80, 1'b0, 2};
    tbl[7]  = '{1'b0, 2'd0, 1'b0, 32'h080, 32'h0,        32'h00000080, 1'b0, 2};
    tbl[8]  = '{1'b0, 2'd1, 1'b1, 32'h082, 32'h0,        32'hFFFF8000, 1'b0, 2};
    tbl[9]  = '{1'b0, 2'd1, 1'b0, 32'h082, 32'h0,        32'h00008000, 1'b0, 2};
    tbl[10] = '{1'b0, 2'd1, 1'b0, 32'h021, 32'h0,        32'h0,        1'b1, 1};
    tbl[11] = '{1'b1, 2'd2, 1'b0, 32'h202, 32'h12345678, 32'h0,        1'b1, 1};
    tbl[12] = '{1'b0, 2'd3, 1'b0, 32'h000, 32'h0,        32'h0,        1'b1, 1};
    tbl[13] = '{1'b1, 2'd3, 1'b0, 32'h040, 32'hFFFFFFFF, 32'h0,        1'b1, 1};
    tbl[14] = '{1'b0, 2'd0, 1'b0, 32'h200, 32'h0,        32'h0,        1'b1, 1};
    tbl[15] = '{1'b1, 2'd2, 1'b0, 32'h044, 32'hCAFEF00D, 32'h0,        1'b0, 2};
    tbl[16] = '{1'b1, 2'd1, 1'b0, 32'h046, 32'h1234BEEF, 32'h0,        1'b0, 3};
    tbl[17] = '{1'b0, 2'd2, 1'b0, 32'h044, 32'h0,        32'hBEEFF00D, 1'b0, 2};
    tbl[18] = '{1'b0, 2'd0, 1'b1, 32'h043, 32'h0,        32'hFFFFFFA5, 1'b0, 2};
    tbl[19] = '{1'b0, 2'd2, 1'b1, 32'h1FC, 32'h0,        32'h0,        1'b0, 2};
    tbl[20] = '{1'b0, 2'd0, 1'b0, 32'h1FF, 32'h0,        32'h0,        1'b0, 2};

    // reset values, asynchronous and ahead of any clock edge
    #2 rst_n = 1'b0;
    #1;
    chk("reset req_ready", 32'(req_ready), 32'd1);
    chk("reset rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset rsp_err", 32'(rsp_err), 32'd0);
    chk("reset rsp_rdata", rsp_rdata, 32'h0);
    chk("reset md_adr", md_adr, 32'h0);
    chk("reset md_din", md_din, 32'h0);
    chk("reset md_w", 32'(md_w), 32'd0);
    chk("reset md_r", 32'(md_r), 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 21; i++)
      do_req($sformatf("tbl%0d", i), tbl[i].st, tbl[i].sz, tbl[i].sg, tbl[i].a,
             tbl[i].wd, 0, 1'b1, tbl[i].erd, tbl[i].eerr, tbl[i].elat);
    chk("byte merge word", mem[16], 32'hA5223344);
    chk("half merge word", mem[17], 32'hBEEFF00D);

    // stalled response with a second request queued behind it
    req_store = 1'b0; req_size = 2'd2; req_signed = 1'b0; req_addr = 32'h010;
    req_valid = 1'b1; rsp_ready = 1'b0;
    @(posedge clk); #1;
    req_addr = 32'h080;
    n = 0;
    while (!rsp_valid && n < 8) begin @(posedge clk); #1; n++; end
    chk("queue first valid", 32'(rsp_valid), 32'd1);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk("queue hold valid", 32'(rsp_valid), 32'd1);
      chk("queue hold rdata", rsp_rdata, 32'hDEADBEEF);
      chk("queue hold req_ready", 32'(req_ready), 32'd0);
      chk("queue no md_r", 32'(md_r), 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("queue first drop", 32'(rsp_valid), 32'd0);
    chk("queue idle ready", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("queue second accepted", 32'(req_ready), 32'd0);
    chk("queue second md_r", 32'(md_r), 32'd1);
    chk("queue second md_adr", md_adr, 32'd32);
    @(posedge clk); #1;
    chk("queue second valid", 32'(rsp_valid), 32'd1);
    chk("queue second rdata", rsp_rdata, 32'h8000FF80);
    @(posedge clk); #1;

    // reset during the READ of a half store
    req_store = 1'b1; req_size = 2'd1; req_addr = 32'h046; req_wdata = 32'h00005555;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("rst mid md_r", 32'(md_r), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst mid md_r drop", 32'(md_r), 32'd0);
    chk("rst mid md_w", 32'(md_w), 32'd0);
    chk("rst mid rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst mid req_ready", 32'(req_ready), 32'd1);
    chk("rst mid md_adr", md_adr, 32'h0);
    chk("rst mid md_din", md_din, 32'h0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    chk("rst mid mem kept", mem[17], 32'hBEEFF00D);
    @(posedge clk); #1;
    do_req("post reset load", 1'b0, 2'd2, 1'b0, 32'h044, 32'h0, 0, 1'b1,
           32'hBEEFF00D, 1'b0, 2);

    // random traffic against the reference model
    for (int i = 0; i < 150; i++) begin
      sz = 2'($urandom_range(0, 3));
      a  = 32'($urandom_range(0, 511));
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'd1) a[0] = 1'b0;
        if (sz == 2'd2) a[1:0] = 2'b00;
      end
      if ($urandom_range(0, 9) == 0) a[9 + $urandom_range(0, 22)] = 1'b1;
      wd = $urandom;
      do_req($sformatf("rnd%0d", i), 1'($urandom_range(0, 1)), sz,
             1'($urandom_range(0, 1)), a, wd, $urandom_range(0, 2), 1'b0,
             32'h0, 1'b0, 0);
    end
    // full memory comparison with the model
    for (int w = 0; w < 128; w++)
      if (mem[w] !== ref_mem[w]) chk($sformatf("final mem %0d", w), mem[w], ref_mem[w]);
    chk("final mem word 16", mem[16], ref_mem[16]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
